// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART sensor framer.
// frame_len gives the total byte count of one frame, including SYNC and TERM.
package uart_frame_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  localparam logic [7:0] DEF_SYNC = 8'hAA;
  localparam logic [7:0] DEF_TERM = 8'h0A;
  localparam int         IDX_W    = 6;

  function automatic int frame_len(int num_ch, int ch_bytes, int csum_en);
    return 2 + num_ch * ch_bytes + csum_en;
  endfunction

endpackage

// File: rtl/uart_sensor_framer_if.sv
// Byte handshake between the framer and the UART transmitter.
interface uart_sensor_framer_if;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;

  modport master (output tx_data, output tx_send, input tx_done);
  modport slave  (input tx_data, input tx_send, output tx_done);
endinterface

// File: rtl/frame_tick_gen.sv
// Periodic tick: pulses in the cycle the counter wraps from PERIOD_CYC-1 to 0.
// While en is low the counter is held at 0.
module frame_tick_gen #(
  parameter int PERIOD_CYC = 100000
) (
  input  logic clk_1MHz,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_sensor_framer.sv
// Snapshots NUM_CH sensor channels and sends them as one framed packet, one byte
// per UART send/done handshake: SYNC, payload (little-endian), optional checksum, TERM.
module uart_sensor_framer
  import uart_frame_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          CH_BYTES   = 2,
  parameter logic [7:0]  SYNC_BYTE  = DEF_SYNC,
  parameter logic [7:0]  TERM_BYTE  = DEF_TERM,
  parameter bit          CSUM_EN    = 1'b1,
  parameter int          PERIOD_CYC = 100000
) (
  input  logic                           clk_1MHz,
  input  logic                           rst,
  input  logic [NUM_CH*CH_BYTES*8-1:0]   ch_data,
  input  logic                           trigger,
  input  logic                           auto_en,
  uart_sensor_framer_if.master           uart,
  output logic                           frame_busy,
  output logic                           frame_done,
  output logic [7:0]                     drop_cnt
);

  localparam int               NB       = NUM_CH * CH_BYTES;
  localparam int               DW       = NB * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_CH, CH_BYTES, int'(CSUM_EN)) - 1);
  localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NB);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    snap_q, snap_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic [7:0]       drop_q, drop_d;

  logic       tick, req, last_byte, is_payload;
  logic [7:0] byte_sel;

  frame_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .en       (auto_en),
    .tick     (tick)
  );

  assign req        = trigger | (auto_en & tick);
  assign last_byte  = (idx_q == LAST_IDX);
  assign is_payload = (idx_q != '0) && (idx_q <= NB_IDX);

  // Index 0 is SYNC, 1..NB the snapshot bytes, then CSUM (if enabled), then TERM.
  always_comb begin
    byte_sel = TERM_BYTE;
    if (idx_q == '0)
      byte_sel = SYNC_BYTE;
    else if (is_payload)
      byte_sel = snap_q[{idx_q - 1'b1, 3'b000} +: 8];
    else if (CSUM_EN && (idx_q == NB_IDX + 1'b1))
      byte_sel = csum_q;
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      csum_q    <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    drop_d    = drop_q;
    // busy_q stays high through the frame_done cycle, so a request there is a drop.
    if (req && busy_q && (drop_q != 8'hFF))
      drop_d = drop_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          snap_d  = ch_data;
          csum_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = byte_sel;
        state_d   = SEND;
      end
      SEND: begin
        if (is_payload) csum_d = csum_q + tx_data_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (uart.tx_done) begin
          if (last_byte) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart.tx_send = (state_q == SEND);
    frame_done   = (state_q == WAIT) && uart.tx_done && last_byte;
  end

  assign uart.tx_data = tx_data_q;
  assign frame_busy   = busy_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_uart_sensor_framer.sv
// Bench for uart_sensor_framer: cycle model + byte scoreboard on a checksum instance,
// a second instance without checksum, and a UART stub answering 20 cycles after each send.
module tb_uart_sensor_framer;
  import uart_frame_pkg::*;

  localparam int P  = 200;
  localparam int L0 = 7;
  localparam int L1 = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ch_data = '0;
  logic        trigger = 1'b0, trig1 = 1'b0, auto_en = 1'b0;
  logic        frame_busy0, frame_done0, frame_busy1, frame_done1;
  logic [7:0]  drop0, drop1;

  uart_sensor_framer_if if0();
  uart_sensor_framer_if if1();

  uart_sensor_framer #(.NUM_CH(2), .CH_BYTES(2), .SYNC_BYTE(8'hAA), .TERM_BYTE(8'h0A),
                       .CSUM_EN(1'b1), .PERIOD_CYC(P)) dut0 (
    .clk_1MHz(clk), .rst(rst), .ch_data(ch_data), .trigger(trigger), .auto_en(auto_en),
    .uart(if0), .frame_busy(frame_busy0), .frame_done(frame_done0), .drop_cnt(drop0));

  uart_sensor_framer #(.NUM_CH(2), .CH_BYTES(2), .SYNC_BYTE(8'hAA), .TERM_BYTE(8'h0A),
                       .CSUM_EN(1'b0), .PERIOD_CYC(P)) dut1 (
    .clk_1MHz(clk), .rst(rst), .ch_data(ch_data), .trigger(trig1), .auto_en(1'b0),
    .uart(if1), .frame_busy(frame_busy1), .frame_done(frame_done1), .drop_cnt(drop1));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int done_at0 = -1, done_at1 = -1;

  logic [7:0] exp0[$], exp1[$], got0[$];
  int         sync_cyc[$];
  int  m_tcnt = 0, m_drop = 0, m_sent = 0, m_next = 0, sends1 = 0, fd0_cnt = 0, fd1_cnt = 0;
  bit  m_busy = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame0(logic [31:0] d);
    logic [7:0] s = '0;
    exp0.push_back(8'hAA);
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(d[i*8 +: 8]);
      s += d[i*8 +: 8];
    end
    exp0.push_back(s);
    exp0.push_back(8'h0A);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // UART stub: tx_done for one cycle, 20 cycles after the cycle of tx_send.
  always @(posedge clk) begin
    #1;
    if0.tx_done = (done_at0 == cyc);
    if1.tx_done = (done_at1 == cyc);
  end

  // Cycle model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    bit busy_cur, req;
    logic [7:0] e;
    busy_cur = m_busy;
    chk("busy0", frame_busy0, m_busy);
    chk("drop0", drop0, m_drop);
    chk("fdone0", frame_done0, m_busy && if0.tx_done && (m_sent == L0));
    if (frame_done0) fd0_cnt++;
    if (if0.tx_send) begin
      if (exp0.size() == 0) chk("unexpected_send0", 1'b1, 1'b0);
      else begin
        e = exp0.pop_front();
        chk("byte0", if0.tx_data, e);
      end
      chk("send_lat0", cyc, m_next);
      if (m_sent == 0) sync_cyc.push_back(cyc);
      got0.push_back(if0.tx_data);
      m_sent++;
      done_at0 = cyc + 20;
    end
    if (if1.tx_send) begin
      if (exp1.size() == 0) chk("unexpected_send1", 1'b1, 1'b0);
      else begin
        e = exp1.pop_front();
        chk("byte1", if1.tx_data, e);
      end
      sends1++;
      done_at1 = cyc + 20;
    end
    if (frame_done1) begin
      fd1_cnt++;
      chk("fdone1_sends", sends1, L1);
      chk("fdone1_txdone", if1.tx_done, 1'b1);
    end

    req = trigger | (auto_en && (m_tcnt == P - 1));
    if (rst) begin
      m_busy = 1'b0; m_drop = 0; m_sent = 0; m_tcnt = 0;
      exp0.delete(); exp1.delete();
      done_at0 = -1; done_at1 = -1;
    end else begin
      m_tcnt = (!auto_en || m_tcnt == P - 1) ? 0 : m_tcnt + 1;
      if (req && busy_cur && m_drop < 255) m_drop++;
      if (busy_cur && if0.tx_done) begin
        if (m_sent == L0) begin
          m_busy = 1'b0;
          m_sent = 0;
        end else m_next = cyc + 2;
      end
      if (req && !busy_cur) begin
        m_busy = 1'b1;
        push_frame0(ch_data);
        m_next = cyc + 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || frame_busy1 || exp1.size() != 0) && n < 600) begin
      step();
      n++;
    end
    chk("idle_timeout", (n < 600), 1'b1);
    repeat (3) step();
  endtask

  task automatic wait_sent(int k);
    int n = 0;
    while (m_sent < k && n < 200) begin
      step();
      n++;
    end
    chk("sent_timeout", (n < 200), 1'b1);
  endtask

  task automatic check_t1(string tag);
    logic [7:0] ref1 [7] = '{8'hAA, 8'h48, 8'h01, 8'h62, 8'h00, 8'hAB, 8'h0A};
    chk({tag, "_len"}, got0.size(), 7);
    for (int i = 0; i < 7 && i < got0.size(); i++) chk(tag, got0[i], ref1[i]);
  endtask

  initial begin
    int c0;
    logic [7:0] ref5 [7] = '{8'hAA, 8'hEF, 8'hBE, 8'h34, 8'h12, 8'hF3, 8'h0A};

    rst = 1'b1;
    repeat (3) step();
    chk("rst_tx_data", if0.tx_data, 8'h00);
    chk("rst_tx_send", if0.tx_send, 1'b0);
    chk("rst_busy", frame_busy0, 1'b0);
    chk("rst_done", frame_done0, 1'b0);
    chk("rst_drop", drop0, 8'h00);
    rst = 1'b0;
    step();

    // Triggered frame on both instances: with and without checksum.
    ch_data = {16'h0062, 16'h0148};
    got0.delete();
    foreach (exp1[i]) exp1.delete(i);
    exp1.push_back(8'hAA); exp1.push_back(8'h48); exp1.push_back(8'h01);
    exp1.push_back(8'h62); exp1.push_back(8'h00); exp1.push_back(8'h0A);
    trigger = 1'b1; trig1 = 1'b1;
    step();
    trigger = 1'b0; trig1 = 1'b0;
    step();
    chk("first_send_lat", if0.tx_send, 1'b1);
    wait_idle();
    check_t1("t1_bytes");
    chk("t1_fdone_cnt", fd0_cnt, 1);
    chk("t2_sends", sends1, L1);
    chk("t2_fdone_cnt", fd1_cnt, 1);

    // Periodic frames: 1000 cycles of auto_en.
    sync_cyc.delete();
    c0 = cyc;
    auto_en = 1'b1;
    repeat (1000) step();
    auto_en = 1'b0;
    wait_idle();
    chk("t3_frames", sync_cyc.size(), 5);
    for (int k = 0; k < 5 && k < sync_cyc.size(); k++)
      chk("t3_tick_lat", sync_cyc[k], c0 + 201 + 200 * k);

    // Requests while busy are dropped; counter saturates.
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (30) step();
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1; step(); trigger = 1'b0;
      repeat (10) step();
    end
    wait_idle();
    chk("t4_drop3", drop0, 8'd3);
    trigger = 1'b1;
    repeat (400) step();
    trigger = 1'b0;
    wait_idle();
    chk("t4_drop_sat", drop0, 8'd255);

    // Snapshot holds when ch_data changes mid-frame.
    got0.delete();
    ch_data = {16'h1234, 16'hBEEF};
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_sent(2);
    ch_data = 32'hFFFF_FFFF;
    wait_idle();
    chk("t5_len", got0.size(), 7);
    for (int i = 0; i < 7 && i < got0.size(); i++) chk("t5_bytes", got0[i], ref5[i]);

    // Reset mid-frame aborts; next frame is complete.
    ch_data = {16'h0062, 16'h0148};
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_sent(3);
    rst = 1'b1;
    step();
    chk("t6_tx_data", if0.tx_data, 8'h00);
    chk("t6_tx_send", if0.tx_send, 1'b0);
    chk("t6_busy", frame_busy0, 1'b0);
    chk("t6_done", frame_done0, 1'b0);
    chk("t6_drop", drop0, 8'h00);
    rst = 1'b0;
    repeat (40) step();
    got0.delete();
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_idle();
    check_t1("t6_bytes");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
